// File: rtl/jtdsp16_pkg.sv
// Shared types and constants for the JTDSP16 external ROM arbiter.
package jtdsp16_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    SEL_PC = 1'b0,
    SEL_PT = 1'b1
  } sel_t;

  localparam int          TOUT_DEF  = 255;
  localparam logic [15:0] TOUT_DATA = 16'hFFFF;

  typedef struct packed {
    logic        vld;
    logic [15:0] addr;
    logic [15:0] data;
  } hit_t;

  // Round-robin between the two requesters; a lone request always wins.
  function automatic sel_t pick_grant(input logic pc_req, input logic pt_req, input sel_t last);
    if (pc_req && pt_req) return (last == SEL_PC) ? SEL_PT : SEL_PC;
    if (pt_req)           return SEL_PT;
    return SEL_PC;
  endfunction

endpackage

// File: rtl/jtdsp16_rom_arb.sv
// Arbitrates program-fetch and table-read requesters onto one external ROM, with a one-entry hit buffer.
// Miss: req->ok 3 cycles + rom_ok wait (timeout TOUT); hit: 2 cycles. Requesters hold req until ok.
module jtdsp16_rom_arb
  import jtdsp16_pkg::*;
#(
  parameter int TOUT = TOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_req,
  input  logic [15:0] pc_addr,
  output logic [15:0] pc_data,
  output logic        pc_ok,
  input  logic        pt_req,
  input  logic [15:0] pt_addr,
  output logic [15:0] pt_data,
  output logic        pt_ok,
  output logic        rom_cs,
  output logic [15:0] rom_addr,
  input  logic [15:0] rom_data,
  input  logic        rom_ok,
  input  logic        flush,
  output logic        err
);

  localparam logic [7:0] CNT_LAST = 8'(TOUT - 1);

  state_t      state, state_nxt;
  sel_t        sel, last, sel_pick;
  hit_t        hit;
  logic [15:0] addr, pick_addr;
  logic [7:0]  cnt;
  logic        deliver, from_hit;
  logic        any_req, is_hit, cur_req, grant, ext_done, tmo, fire;

  assign any_req  = pc_req | pt_req;
  assign rom_addr = addr;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (any_req) state_nxt = is_hit ? ST_DONE : ST_BUSY;
      ST_BUSY: if (rom_ok || tmo) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    sel_pick  = pick_grant(pc_req, pt_req, last);
    pick_addr = (sel_pick == SEL_PT) ? pt_addr : pc_addr;
    is_hit    = hit.vld && (hit.addr == pick_addr);
    cur_req   = (sel == SEL_PT) ? pt_req : pc_req;
    grant     = (state == ST_IDLE) && any_req;
    ext_done  = (state == ST_BUSY) && rom_ok;
    tmo       = (state == ST_BUSY) && !rom_ok && (cnt == CNT_LAST);
    fire      = (state == ST_DONE) && deliver;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel      <= SEL_PC;
      last     <= SEL_PC;
      addr     <= '0;
      cnt      <= '0;
      deliver  <= 1'b0;
      from_hit <= 1'b0;
      hit      <= '0;
      rom_cs   <= 1'b0;
      pc_data  <= '0;
      pt_data  <= '0;
      pc_ok    <= 1'b0;
      pt_ok    <= 1'b0;
      err      <= 1'b0;
    end else begin
      pc_ok <= 1'b0;
      pt_ok <= 1'b0;

      if (grant) begin
        sel      <= sel_pick;
        last     <= sel_pick;
        addr     <= pick_addr;
        from_hit <= is_hit;
        deliver  <= 1'b1;
        cnt      <= '0;
        rom_cs   <= !is_hit;
      end

      if (ext_done) begin
        // The bus cycle always completes and refills the buffer, even if the requester gave up.
        rom_cs   <= 1'b0;
        deliver  <= cur_req;
        hit.vld  <= 1'b1;
        hit.addr <= addr;
        hit.data <= rom_data;
        if (cur_req) begin
          if (sel == SEL_PT) pt_data <= rom_data;
          else               pc_data <= rom_data;
        end
      end else if (tmo) begin
        rom_cs <= 1'b0;
        err    <= 1'b1;
        if (sel == SEL_PT) pt_data <= TOUT_DATA;
        else               pc_data <= TOUT_DATA;
      end else if (state == ST_BUSY) begin
        cnt <= cnt + 8'd1;
      end

      if (fire) begin
        if (sel == SEL_PT) pt_ok <= 1'b1;
        else               pc_ok <= 1'b1;
        if (from_hit) begin
          if (sel == SEL_PT) pt_data <= hit.data;
          else               pc_data <= hit.data;
        end
      end

      if (flush) hit.vld <= 1'b0;
    end
  end

endmodule

// File: doc/jtdsp16_rom_arb.md
JTDSP16_ROM_ARB -- requirements
Module: jtdsp16_rom_arb

Interface
REQ-001 SHALL have parameter TOUT, default 255, meaning external-access timeout in clock cycles (range 2..255).
REQ-002 SHALL have port clk  in  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports pc_req in 1, pc_addr in 16, pc_data out 16, pc_ok out 1: program-fetch requester.
REQ-005 SHALL have ports pt_req in 1, pt_addr in 16, pt_data out 16, pt_ok out 1: table-read requester.
REQ-006 SHALL have ports rom_cs out 1, rom_addr out 16, rom_data in 16, rom_ok in 1: shared external ROM bus.
REQ-007 SHALL have ports flush in 1 (invalidate hit buffer) and err out 1 (sticky timeout flag).

Function
REQ-008 SHALL implement FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-009 In IDLE with any req high, SHALL grant one requester and latch its address; rom_cs=1 with rom_addr=latched address from the next cycle (state BUSY).
REQ-010 When both reqs are high in IDLE, SHALL grant the requester not granted last; after reset the PT requester has priority.
REQ-011 A single pending req SHALL be granted regardless of last-grant history.
REQ-012 rom_cs and rom_addr SHALL remain stable throughout BUSY; requester address changes after grant SHALL be ignored.
REQ-013 On rom_ok sampled high in BUSY, SHALL register rom_data into the granted requester's data output, drop rom_cs, and enter DONE.
REQ-014 In DONE, SHALL pulse the granted requester's ok for exactly one cycle, then return to IDLE; other requester's ok stays 0.
REQ-015 Data outputs SHALL hold their last value until the next completion for that requester.
REQ-016 If the granted req is low when rom_ok arrives, SHALL complete the bus cycle, update the hit buffer, suppress the ok pulse and the data update.
REQ-017 SHALL keep a one-entry hit buffer (16-bit address, 16-bit data, valid bit) loaded on every successful external completion.
REQ-018 A granted request whose address matches a valid hit buffer SHALL skip BUSY: data loaded and ok pulsed one cycle after grant, rom_cs never asserted.
REQ-019 flush high SHALL clear the valid bit at the next edge; if flush coincides with a completion, flush wins (valid=0).
REQ-020 SHALL count cycles in BUSY; on reaching TOUT without rom_ok, SHALL drop rom_cs, set err, pulse the requester's ok with data 16'hFFFF, and not load the hit buffer.
REQ-021 rom_ok outside BUSY SHALL be ignored.
REQ-022 err SHALL stay set until rst.
REQ-023 Worst-case external latency: req-high to ok = 3 cycles plus rom_ok wait; hit latency: 2 cycles.

Reset
REQ-024 On rst: state IDLE, rom_cs=0, rom_addr=0, pc_data=pt_data=0, pc_ok=pt_ok=0, err=0, hit valid=0, timeout counter=0, last-grant=PC.
REQ-025 rst during BUSY SHALL abort the access immediately (rom_cs=0 next edge) with no ok pulse.

Structure
REQ-026 FSM state encoding and TOUT default SHALL live in the shared package jtdsp16_pkg.
REQ-027 Single module; no sub-modules required; the hit buffer is inline registers.

Verification
REQ-028 pc_req=1, pc_addr=16'h1234, rom_ok two cycles after rom_cs with data 16'hABCD -> rom_addr=16'h1234, pc_data=16'hABCD, one pc_ok pulse.
REQ-029 pc_req and pt_req rise together after reset (pt_addr=16'h2000, pc_addr=16'h1000) -> PT served first, then PC; each ok pulses once.
REQ-030 Repeat pt read of 16'h2000 after completion -> no rom_cs, pt_ok 2 cycles after req, data matches; after flush, same read asserts rom_cs.
REQ-031 rom_ok held low, TOUT=4 -> rom_cs drops after 4 BUSY cycles, ok pulses with 16'hFFFF, err=1 until rst.
REQ-032 pc_req dropped during BUSY, rom_ok later -> no pc_ok, pc_data unchanged, hit buffer updated.
REQ-033 rst asserted mid-BUSY -> rom_cs=0 next cycle, all outputs at reset values, no ok pulse.
